// File: rtl/vga_timing_sequencer.sv
// VGA raster timing sequencer: pixel-rate divider, x/y scan counters and sync/blank decode.
// Optional build macro VGA_SYNC_REG_EN registers hsync/vsync/video_on on the pixel tick.
`timescale 1ns/1ps

module vga_timing_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_start,
  output logic       busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int              DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] divider;
  logic             frame_last;
  logic             h_sync_act;
  logic             v_sync_act;
  logic             vis_act;

  // The divider sits at 0 in IDLE, so the tick can never fire outside a scan.
  assign pixel_tick  = (divider == DIV_LAST);
  assign frame_last  = pixel_tick && (pixel_x == H_LAST) && (pixel_y == V_LAST);
  assign line_end    = pixel_tick && (pixel_x == H_LAST);
  assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // Dropping run only arms the stop; the scan always runs out to the last pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN, S_DRAIN: begin
          if (frame_last && !run) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (run) begin
            state <= S_RUN;
          end else begin
            state <= S_DRAIN;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divider <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (state == S_IDLE) begin
      divider <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      divider <= pixel_tick ? '0 : divider + 1'b1;
      if (pixel_tick) begin
        if (pixel_x == H_LAST) begin
          pixel_x <= '0;
          pixel_y <= (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end else begin
          pixel_x <= pixel_x + 10'd1;
        end
      end
    end
  end

  assign h_sync_act = busy && (pixel_x >= HS_START) && (pixel_x < HS_END);
  assign v_sync_act = busy && (pixel_y >= VS_START) && (pixel_y < VS_END);
  assign vis_act    = busy && (pixel_x < H_VIS) && (pixel_y < V_VIS);

`ifdef VGA_SYNC_REG_EN
  // Registered decode trails the counters by one pixel period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (state == S_IDLE || (frame_last && !run)) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (pixel_tick) begin
      hsync    <= ~h_sync_act;
      vsync    <= ~v_sync_act;
      video_on <= vis_act;
    end
  end
`else
  assign hsync    = ~h_sync_act;
  assign vsync    = ~v_sync_act;
  assign video_on = vis_act;
`endif

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Self-checking bench for vga_timing_sequencer on a shrunken 15x11 raster with a divide-by-4 pixel clock.
`timescale 1ns/1ps

module tb_vga_timing_sequencer;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int TD = 4;
  localparam int HT = HA + HFP + HS + HBP;   // 15
  localparam int VT = VA + VFP + VS + VBP;   // 11
  localparam int FRAME_PIX = HT * VT;        // 165
  localparam int BUDGET = 2 * FRAME_PIX * TD;
  localparam logic [26:0] IDLE_OUT = {1'b0, 20'd0, 3'b110, 3'b000};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       pixel_tick, hsync, vsync, video_on, line_end, frame_start, busy;
  logic [9:0] pixel_x, pixel_y;
  logic [26:0] dut_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  vga_timing_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .line_end(line_end), .frame_start(frame_start), .busy(busy)
  );

  assign dut_out = {pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_end, frame_start, busy};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a scan is a count of clocks since it started; position is plain division.
  bit m_active = 1'b0;
  int m_n = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_n      <= 0;
    end else if (!m_active) begin
      if (run) begin
        m_active <= 1'b1;
        m_n      <= 0;
      end
    end else if ((m_n % TD == TD - 1) && ((m_n / TD) % FRAME_PIX == FRAME_PIX - 1) && !run) begin
      m_active <= 1'b0;
      m_n      <= 0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // {hsync, vsync, video_on} for global pixel index q.
  function automatic logic [2:0] sync_of(input int q);
    int x = q % HT;
    int y = (q / HT) % VT;
    return {!(x >= HA + HFP && x < HA + HFP + HS),
            !(y >= VA + VFP && y < VA + VFP + VS),
            (x < HA && y < VA)};
  endfunction

  function automatic logic [26:0] model_out();
    int p, x, y;
    logic tick;
    logic [2:0] s;
    if (!m_active) return IDLE_OUT;
    p    = m_n / TD;
    x    = p % HT;
    y    = (p / HT) % VT;
    tick = (m_n % TD == TD - 1);
`ifdef VGA_SYNC_REG_EN
    s = (p == 0) ? 3'b110 : sync_of(p - 1);
`else
    s = sync_of(p);
`endif
    return {tick, 10'(x), 10'(y), s, tick && (x == HT - 1), tick && (x == 0) && (y == 0), 1'b1};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) check("model", 32'(dut_out), 32'(model_out()));
  end

  task automatic wait_y(input int yv, input string name);
    int b = 0;
    while (pixel_y != 10'(yv) && b < BUDGET) begin @(negedge clk); b++; end
    check(name, 32'(pixel_y), yv);
  endtask

  task automatic wait_x(input int xv, input string name);
    int b = 0;
    while (pixel_x != 10'(xv) && b < BUDGET) begin @(negedge clk); b++; end
    check(name, 32'(pixel_x), xv);
  endtask

  task automatic wait_fs(input string name);
    int b = 0;
    while (!frame_start && b < BUDGET) begin @(negedge clk); b++; end
    check(name, 32'(frame_start), 1);
  endtask

  // Collect statistics over one frame, from a frame_start cycle up to the next.
  task automatic measure_frame(output int clks, output int ticks, output int lines,
                               output int hlow, output int vlow, output int von,
                               output int hfirst);
    clks = 0; ticks = 0; lines = 0; hlow = 0; vlow = 0; von = 0; hfirst = -1;
    wait_fs("measure_start");
    do begin
      clks++;
      if (pixel_tick) begin
        ticks++;
        if (line_end) lines++;
        if (!hsync) begin
          hlow++;
          if (hfirst < 0) hfirst = int'(pixel_x);
        end
        if (!vsync) vlow++;
        if (video_on) von++;
      end
      @(negedge clk);
    end while (!frame_start && clks < BUDGET);
  endtask

  initial begin
    int k, lx, ly, t0, c_rel;
    int clks, ticks, lines, hlow, vlow, von, hfirst;

    // Reset held with run requested.
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_hold", 32'(dut_out), 32'(IDLE_OUT));
    cmp_en = 1'b1;

    // Release: busy on the first edge, first tick on the fourth sampled cycle.
    reset_n = 1'b1;
    @(negedge clk);
    check("busy_after_release", 32'(busy), 1);
    k = 1;
    while (!pixel_tick && k < 20) begin @(negedge clk); k++; end
    check("first_tick_delay", k, TD);
    check("first_tick_x", 32'(pixel_x), 0);
    check("first_tick_frame_start", 32'(frame_start), 1);
    @(negedge clk);
    check("x_after_first_tick", 32'(pixel_x), 1);

    // One full frame with run held high.
    measure_frame(clks, ticks, lines, hlow, vlow, von, hfirst);
    check("frame_clks", clks, 660);
    check("frame_ticks", ticks, 165);
    check("frame_line_ends", lines, 11);
    check("hsync_low_ticks", hlow, 33);
    check("vsync_low_ticks", vlow, 30);
    check("video_on_ticks", von, 48);
`ifdef VGA_SYNC_REG_EN
    check("hsync_first_low_x", hfirst, 11);
`else
    check("hsync_first_low_x", hfirst, 10);
`endif

    // Drop run mid-frame: scan drains to the last pixel, then idles.
    wait_y(3, "drop_at_y3");
    run = 1'b0;
    repeat (8) @(negedge clk);
    check("drain_busy", 32'(busy), 1);
    lx = -1; ly = -1; k = 0;
    while (busy && k < BUDGET) begin
      lx = int'(pixel_x); ly = int'(pixel_y);
      @(negedge clk); k++;
    end
    check("drain_ended", 32'(busy), 0);
    check("drain_last_x", lx, HT - 1);
    check("drain_last_y", ly, VT - 1);
    k = 0;
    repeat (20) begin
      @(negedge clk);
      if (pixel_tick) k++;
    end
    check("idle_no_ticks", k, 0);
    check("idle_outputs", 32'(dut_out), 32'(IDLE_OUT));

    // Drop then re-raise run inside a frame: frame period unchanged.
    run = 1'b1;
    wait_fs("rerun_fs");
    t0 = cyc;
    @(negedge clk);
    wait_y(2, "blip_drop_y2");
    run = 1'b0;
    wait_y(5, "blip_raise_y5");
    check("blip_still_busy", 32'(busy), 1);
    run = 1'b1;
    @(negedge clk);
    wait_fs("blip_next_fs");
    check("blip_frame_period", cyc - t0, 660);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    wait_y(4, "rst_at_y4");
    wait_x(5, "rst_at_x5");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_async", 32'(dut_out), 32'(IDLE_OUT));
    repeat (2) @(negedge clk);
    check("reset_held_mid", 32'(dut_out), 32'(IDLE_OUT));
    reset_n = 1'b1;
    c_rel = cyc;
    wait_fs("restart_fs");
    check("restart_latency", cyc - c_rel, TD);
    repeat (50) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
